// File: rtl/popcount_accum.sv
// Two-stage population counter: stage 1 counts ones or zeros of a sample,
// stage 2 accumulates the counts into a saturating running total.
module popcount_accum #(
  parameter  int unsigned WIDTH     = 8,
  parameter  int unsigned ACC_WIDTH = 16,
  localparam int unsigned CW        = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 mode,
  input  logic                 clear,
  output logic [CW-1:0]        count,
  output logic                 count_valid,
  output logic [ACC_WIDTH-1:0] total,
  output logic                 sat,
  output logic [15:0]          samples
);

  localparam int unsigned             SUM_W   = ACC_WIDTH + 1;
  localparam logic [ACC_WIDTH-1:0]    ACC_MAX = '1;

  logic [WIDTH-1:0]     w_src;
  logic [CW-1:0]        w_ones;
  logic [SUM_W-1:0]     w_sum;
  logic                 w_ovf;

  logic [CW-1:0]        r_count;
  logic                 r_count_valid;
  logic [ACC_WIDTH-1:0] r_total;
  logic                 r_sat;
  logic [15:0]          r_samples;

  // Counting zeros is counting ones of the inverted sample.
  assign w_src = mode ? ~in_data : in_data;

  always_comb begin
    w_ones = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_ones = w_ones + CW'(w_src[i]);
    end
  end

  // One extra bit catches any sum beyond the representable maximum.
  assign w_sum = {1'b0, r_total} + SUM_W'(r_count);
  assign w_ovf = w_sum[ACC_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count       <= '0;
      r_count_valid <= 1'b0;
      r_total       <= '0;
      r_sat         <= 1'b0;
      r_samples     <= '0;
    end else begin
      r_count_valid <= in_valid;
      if (in_valid) begin
        r_count <= w_ones;
      end
      // Clear wins over a simultaneous accumulate; stage 1 is unaffected.
      if (clear) begin
        r_total   <= '0;
        r_sat     <= 1'b0;
        r_samples <= '0;
      end else if (r_count_valid) begin
        r_samples <= r_samples + 16'd1;
        if (r_sat || w_ovf) begin
          r_total <= ACC_MAX;
          r_sat   <= 1'b1;
        end else begin
          r_total <= w_sum[ACC_WIDTH-1:0];
        end
      end
    end
  end

  assign count       = r_count;
  assign count_valid = r_count_valid;
  assign total       = r_total;
  assign sat         = r_sat;
  assign samples     = r_samples;

endmodule

// File: tb/tb_popcount_accum.sv
// Bench for popcount_accum: three instances (8/16, 4/16, 8/6) share stimulus;
// per-sample counts go through a scoreboard, totals are checked per scenario.
module tb_popcount_accum;

  logic       clk = 1'b0;
  logic       rst, in_valid, mode, clear;
  logic [7:0] in_data;

  logic [3:0]  a_count;  logic a_cv; logic [15:0] a_total; logic a_sat; logic [15:0] a_samples;
  logic [2:0]  b_count;  logic b_cv; logic [15:0] b_total; logic b_sat; logic [15:0] b_samples;
  logic [3:0]  c_count;  logic c_cv; logic [5:0]  c_total; logic c_sat; logic [15:0] c_samples;

  popcount_accum #(.WIDTH(8), .ACC_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .mode(mode), .clear(clear),
    .count(a_count), .count_valid(a_cv), .total(a_total), .sat(a_sat), .samples(a_samples));

  popcount_accum #(.WIDTH(4), .ACC_WIDTH(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data[3:0]), .mode(mode), .clear(clear),
    .count(b_count), .count_valid(b_cv), .total(b_total), .sat(b_sat), .samples(b_samples));

  popcount_accum #(.WIDTH(8), .ACC_WIDTH(6)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .mode(mode), .clear(clear),
    .count(c_count), .count_valid(c_cv), .total(c_total), .sat(c_sat), .samples(c_samples));

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int c;
    int due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every accepted sample must appear exactly one edge later.
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   ev;
    if (mon_en) begin
      while (q.size() != 0 && q[0].due < cyc) begin
        n_cmp++; n_err++;
        $display("FAIL sb_lost: sample due cycle %0d never matched (now %0d)", q[0].due, cyc);
        void'(q.pop_front());
      end
      ev = (q.size() != 0 && q[0].due == cyc);
      n_cmp++;
      if (a_cv !== ev || b_cv !== ev || c_cv !== ev) begin
        n_err++;
        $display("FAIL sb_valid cyc %0d: count_valid a/b/c got %b%b%b want %b", cyc, a_cv, b_cv, c_cv, ev);
      end
      if (ev) begin
        e = q.pop_front();
        n_cmp++;
        if (a_count !== 4'(e.a) || b_count !== 3'(e.b) || c_count !== 4'(e.c)) begin
          n_err++;
          $display("FAIL sb_count cyc %0d: got a=%0d b=%0d c=%0d want a=%0d b=%0d c=%0d",
                   cyc, a_count, b_count, c_count, e.a, e.b, e.c);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic m, input logic c, input logic r);
    exp_t e;
    in_valid = v; in_data = d; mode = m; clear = c; rst = r;
    if (v && !r) begin
      e.a   = m ? 8 - $countones(d) : $countones(d);
      e.b   = m ? 4 - $countones(d[3:0]) : $countones(d[3:0]);
      e.c   = e.a;
      e.due = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1);
    n_cmp++; if (a_count !== 4'd0 || a_cv !== 1'b0) begin n_err++; $display("FAIL rst_count got %0d/%b want 0/0", a_count, a_cv); end
    n_cmp++; if (a_total !== 16'd0 || a_sat !== 1'b0) begin n_err++; $display("FAIL rst_total got %0d/%b want 0/0", a_total, a_sat); end
    n_cmp++; if (a_samples !== 16'd0) begin n_err++; $display("FAIL rst_samples got %0d want 0", a_samples); end
    n_cmp++; if (b_total !== 16'd0 || c_total !== 6'd0) begin n_err++; $display("FAIL rst_bc got %0d/%0d want 0/0", b_total, c_total); end
    idle();
    mon_en = 1'b1;
  endtask

  task automatic test_sweep();
    logic [2:0] exp_b [16] = '{0,1,1,2,1,2,2,3,1,2,2,3,2,3,3,4};
    do_clear();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (b_count !== exp_b[i]) begin n_err++; $display("FAIL sweep_count[%0d] got %0d want %0d", i, b_count, exp_b[i]); end
    end
    idle(); idle();
    n_cmp++; if (b_total !== 16'd32 || b_samples !== 16'd16) begin n_err++; $display("FAIL sweep_total got %0d/%0d want 32/16", b_total, b_samples); end
    n_cmp++; if (a_total !== 16'd32) begin n_err++; $display("FAIL sweep_total_a got %0d want 32", a_total); end
  endtask

  task automatic test_mode_zeros();
    int   exp_t_arr [5] = '{0, 4, 8, 12, 12};
    logic exp_v [5]     = '{1, 1, 1, 0, 0};
    do_clear();
    n_cmp++; if (a_total !== 16'd0) begin n_err++; $display("FAIL zeros_clr got %0d want 0", a_total); end
    for (int i = 0; i < 5; i++) begin
      drive(i < 3, 8'h0F, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (a_total !== 16'(exp_t_arr[i]) || c_total !== 6'(exp_t_arr[i]) || a_count !== 4'd4 || a_cv !== exp_v[i])
        begin n_err++; $display("FAIL zeros[%0d] total a/c=%0d/%0d count=%0d v=%b want %0d/%0d 4 %b",
                                i, a_total, c_total, a_count, a_cv, exp_t_arr[i], exp_t_arr[i], exp_v[i]); end
    end
  endtask

  task automatic test_saturate();
    int t;
    do_clear();
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
      t = (k - 1) * 8;
      n_cmp++;
      if (c_total !== ((t > 63) ? 6'd63 : 6'(t)) || c_sat !== (t > 63) || a_total !== 16'(t))
        begin n_err++; $display("FAIL sat_ramp[%0d] c=%0d sat=%b a=%0d want c=%0d sat=%b a=%0d",
                                k, c_total, c_sat, a_total, (t > 63) ? 63 : t, t > 63, t); end
    end
    idle(); idle();
    n_cmp++; if (c_total !== 6'd63 || c_sat !== 1'b1) begin n_err++; $display("FAIL sat_hold got %0d/%b want 63/1", c_total, c_sat); end
    // Landing exactly on the maximum must not flag saturation.
    do_clear();
    for (int k = 0; k < 7; k++) drive(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h7F, 1'b0, 1'b0, 1'b0);
    idle(); idle();
    n_cmp++; if (c_total !== 6'd63 || c_sat !== 1'b0) begin n_err++; $display("FAIL sat_exact got %0d/%b want 63/0", c_total, c_sat); end
    drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    idle(); idle();
    n_cmp++; if (c_total !== 6'd63 || c_sat !== 1'b1 || a_total !== 16'd64) begin n_err++; $display("FAIL sat_over got %0d/%b a=%0d want 63/1 a=64", c_total, c_sat, a_total); end
    drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    idle(); idle();
    n_cmp++; if (c_total !== 6'd63 || c_sat !== 1'b1) begin n_err++; $display("FAIL sat_sticky got %0d/%b want 63/1", c_total, c_sat); end
  endtask

  task automatic test_clear_collision();
    do_clear();
    drive(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h1F, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (a_total !== 16'd8 || a_samples !== 16'd1) begin n_err++; $display("FAIL clr_pre got %0d/%0d want 8/1", a_total, a_samples); end
    drive(1'b1, 8'h03, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (a_total !== 16'd0 || a_sat !== 1'b0 || a_samples !== 16'd0) begin n_err++; $display("FAIL clr_hit got %0d/%b/%0d want 0/0/0", a_total, a_sat, a_samples); end
    idle();
    n_cmp++; if (a_total !== 16'd2 || a_samples !== 16'd1) begin n_err++; $display("FAIL clr_after got %0d/%0d want 2/1", a_total, a_samples); end
    idle();
  endtask

  task automatic test_idle_interleave();
    logic       v_in  [6] = '{1, 0, 0, 1, 0, 0};
    logic [7:0] d_in  [6] = '{8'h81, 8'hAA, 8'h55, 8'hF7, 8'hFF, 8'h00};
    logic       exp_v [6] = '{1, 0, 0, 1, 0, 0};
    int         exp_c [6] = '{2, 2, 2, 7, 7, 7};
    int         exp_s [6] = '{0, 2, 2, 2, 9, 9};
    do_clear();
    for (int i = 0; i < 6; i++) begin
      drive(v_in[i], d_in[i], 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (a_cv !== exp_v[i] || a_count !== 4'(exp_c[i]) || a_total !== 16'(exp_s[i]))
        begin n_err++; $display("FAIL idle[%0d] v=%b count=%0d total=%0d want %b %0d %0d",
                                i, a_cv, a_count, a_total, exp_v[i], exp_c[i], exp_s[i]); end
    end
  endtask

  task automatic test_reset_inflight();
    do_clear();
    drive(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h0F, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (a_total !== 16'd2) begin n_err++; $display("FAIL rfl_pre got %0d want 2", a_total); end
    drive(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (a_count !== 4'd0 || a_cv !== 1'b0 || a_total !== 16'd0 || a_samples !== 16'd0 || a_sat !== 1'b0)
      begin n_err++; $display("FAIL rfl_rst got count=%0d v=%b total=%0d samples=%0d sat=%b want all 0",
                              a_count, a_cv, a_total, a_samples, a_sat); end
    idle();
    n_cmp++; if (a_total !== 16'd0 || a_cv !== 1'b0) begin n_err++; $display("FAIL rfl_drop got %0d/%b want 0/0", a_total, a_cv); end
    drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    idle();
    n_cmp++; if (a_total !== 16'd1 || a_samples !== 16'd1) begin n_err++; $display("FAIL rfl_after got %0d/%0d want 1/1", a_total, a_samples); end
    idle();
  endtask

  task automatic test_samples_wrap();
    do_clear();
    for (int i = 0; i < 65535; i++) drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    idle(); idle();
    n_cmp++; if (a_samples !== 16'd65535 || a_total !== 16'd0) begin n_err++; $display("FAIL wrap_pre got %0d/%0d want 65535/0", a_samples, a_total); end
    drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    idle(); idle();
    n_cmp++; if (a_samples !== 16'd0 || a_total !== 16'd0 || a_sat !== 1'b0) begin n_err++; $display("FAIL wrap_zero got %0d/%0d/%b want 0/0/0", a_samples, a_total, a_sat); end
    drive(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    idle(); idle();
    n_cmp++; if (a_samples !== 16'd1 || a_total !== 16'd1) begin n_err++; $display("FAIL wrap_after got %0d/%0d want 1/1", a_samples, a_total); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_mode_zeros();
    test_saturate();
    test_clear_collision();
    test_idle_interleave();
    test_reset_inflight();
    test_samples_wrap();
    idle(); idle();
    n_cmp++;
    if (q.size() != 0) begin n_err++; $display("FAIL sb_leftover got %0d entries want 0", q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/popcount_accum.md
POPCOUNT_ACCUM -- requirements
Module: popcount_accum

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: number of input signal lines counted per sample (legal range 2..64).
REQ-002 The block SHALL have parameter ACC_WIDTH, default 16: width of the running total (legal range CW..32).
REQ-003 The block SHALL define CW = $clog2(WIDTH+1) as the per-sample count width (4 for WIDTH=8).
REQ-004 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port in_valid  input  1  in_data holds a sample to count this cycle.
REQ-007 The block SHALL have port in_data  input  WIDTH  signal lines to be counted.
REQ-008 The block SHALL have port mode  input  1  0 = count ones, 1 = count zeros; sampled with in_valid.
REQ-009 The block SHALL have port clear  input  1  synchronous clear of total and sat.
REQ-010 The block SHALL have port count  output  CW  registered per-sample count.
REQ-011 The block SHALL have port count_valid  output  1  count holds a new result this cycle.
REQ-012 The block SHALL have port total  output  ACC_WIDTH  registered running sum of accepted counts.
REQ-013 The block SHALL have port sat  output  1  sticky flag: total has saturated.
REQ-014 The block SHALL have port samples  output  16  number of accepted samples since reset/clear, wrapping modulo 2^16.

Function
REQ-015 Stage 1 SHALL register, on each edge with in_valid=1, count = number of 1 bits (mode=0) or 0 bits (mode=1) of in_data; count_valid = in_valid, one cycle latency.
REQ-016 When in_valid=0, count SHALL hold its previous value and count_valid SHALL be 0.
REQ-017 Stage 2 SHALL, on each edge with count_valid=1 and clear=0, add zero-extended count to total and increment samples; total update latency is 2 cycles from in_valid.
REQ-018 Back-to-back in_valid every cycle SHALL be accepted without stall or loss; no backpressure exists.
REQ-019 If total + count exceeds 2^ACC_WIDTH-1, total SHALL become 2^ACC_WIDTH-1 and sat SHALL be set; a sum exactly equal to the maximum SHALL NOT set sat.
REQ-020 Once sat=1, total SHALL hold at the maximum and sat SHALL stay 1 until clear or rst.
REQ-021 clear=1 SHALL set total=0, samples=0, sat=0 on the next edge, taking priority over a simultaneous stage-2 accumulate, whose count is discarded.
REQ-022 clear SHALL NOT affect stage 1: a sample accepted in the clear cycle SHALL appear on count/count_valid one cycle later and be accumulated normally after the clear.
REQ-023 samples SHALL wrap from 65535 to 0 without affecting total or sat.
REQ-024 All outputs SHALL be driven directly from registers; no combinational path from inputs to outputs.

Reset
REQ-025 rst=1 SHALL, on the next edge, set count=0, count_valid=0, total=0, samples=0, sat=0, overriding in_valid and clear.
REQ-026 A sample in flight in either stage when rst is asserted SHALL be discarded; the first in_valid after rst deasserts SHALL produce count_valid one cycle later.

Verification
REQ-027 WIDTH=4: sweep in_data 0..15 one per cycle, mode=0 -> count = 0,1,1,2,1,2,2,3,1,2,2,3,2,3,3,4 one cycle after each; final total=32, samples=16.
REQ-028 WIDTH=8, mode=1, in_data=8'h0F valid 3 cycles back-to-back -> count=4 each cycle, total=4,8,12 on cycles 2,3,4 after first valid.
REQ-029 WIDTH=8, ACC_WIDTH=6: in_data=8'hFF valid 8 cycles -> total 8..56, then 63 with sat=1 on the 8th accumulate; further samples leave total=63, sat=1.
REQ-030 clear asserted in the cycle stage 2 holds count=5 while in_data=8'h03 is presented -> total=0, sat=0 next edge, then total=2 one edge later.
REQ-031 rst asserted for one cycle with both stages holding valid data -> all outputs 0 next edge; no accumulation of the in-flight samples.
REQ-032 Idle cycles (in_valid=0) interleaved with valid samples -> count holds, count_valid=0, total unchanged during idle cycles.
